// File: rtl/phase_timer_pkg.sv
// phase_timer_pkg: FSM state encoding and default marker constants shared by
// the phase timer blocks.
package phase_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DEF_MARKER_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_START_WORD  = 32'h0000_0001;
    localparam logic [31:0] DEF_DONE_WORD   = 32'h7fff_ffff;
    localparam logic [31:0] DEF_ABORT_WORD  = 32'h0000_0000;

endpackage

// File: rtl/phase_counter.sv
// phase_counter: CNT_W-bit saturating up-counter with synchronous clear and a
// sticky overflow flag raised when an increment is requested at all-ones.
module phase_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Clear wins over enable so a restart marker never leaks a count.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (en) begin
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/phase_timer_ctrl.sv
// phase_timer_ctrl: snoops picoRV32 marker writes and times firmware phases.
// Define PHASE_TIMER_TOTAL_EN to add the saturating total-RUN-cycles port.
module phase_timer_ctrl
    import phase_timer_pkg::*;
#(
    parameter int unsigned N_PHASES    = 4,
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] MARKER_ADDR = DEF_MARKER_ADDR,
    parameter logic [31:0] START_WORD  = DEF_START_WORD,
    parameter logic [31:0] DONE_WORD   = DEF_DONE_WORD,
    parameter logic [31:0] ABORT_WORD  = DEF_ABORT_WORD
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_valid,
    input  logic                        mem_ready,
    input  logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_wstrb,
    input  logic [$clog2(N_PHASES)-1:0] rd_sel,
    output logic [CNT_W-1:0]            rd_data,
    output logic [$clog2(N_PHASES)-1:0] phase,
    output logic                        busy,
    output logic                        done,
    output logic [N_PHASES-1:0]         ovf
`ifdef PHASE_TIMER_TOTAL_EN
    ,
    output logic [CNT_W-1:0]            total
`endif
);

    localparam int unsigned          SEL_W      = $clog2(N_PHASES);
    localparam logic [SEL_W-1:0]     LAST_PHASE = SEL_W'(N_PHASES - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic             marker;
    logic             mk_start, mk_done, mk_abort;
    logic             clr_all;
    logic [N_PHASES-1:0] cnt_en;
    logic [CNT_W-1:0] cnt [N_PHASES];

    // Only full-word writes that complete their handshake count as markers.
    assign marker   = mem_valid & mem_ready & (mem_wstrb == 4'hF) & (mem_addr == MARKER_ADDR);
    assign mk_start = marker & (mem_wdata == START_WORD);
    assign mk_done  = marker & (mem_wdata == DONE_WORD);
    assign mk_abort = marker & (mem_wdata == ABORT_WORD);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        clr_all = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mk_start) begin
                    state_d = RUN;
                    phase_d = '0;
                    clr_all = 1'b1;
                end
            end
            RUN: begin
                if (mk_start) begin
                    phase_d = '0;
                    clr_all = 1'b1;
                end else if (mk_done) begin
                    if (phase_q == LAST_PHASE) begin
                        state_d = DONE;
                    end else begin
                        phase_d = phase_q + SEL_W'(1);
                    end
                end else if (mk_abort) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (mk_start) begin
                    state_d = RUN;
                    phase_d = '0;
                    clr_all = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The closing marker's own cycle still belongs to the phase it closes.
    always_comb begin
        cnt_en = '0;
        for (int unsigned i = 0; i < N_PHASES; i++) begin
            cnt_en[i] = (state_q == RUN) && (phase_q == SEL_W'(i));
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < N_PHASES; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rd_data_q <= rd_data_d;
        end
    end

    for (genvar g = 0; g < N_PHASES; g++) begin : g_phase
        phase_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .clr  (clr_all),
            .en   (cnt_en[g]),
            .count(cnt[g]),
            .ovf  (ovf[g])
        );
    end

`ifdef PHASE_TIMER_TOTAL_EN
    logic total_ovf;

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_total (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_all),
        .en   (state_q == RUN),
        .count(total),
        .ovf  (total_ovf)
    );
`endif

    assign rd_data = rd_data_q;
    assign phase   = phase_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// tb_phase_timer_ctrl: directed marker sequences with a scoreboard queue; a
// negedge monitor pops expected observations and compares them to the DUTs.
module tb_phase_timer_ctrl;

    localparam logic [31:0] MADDR   = 32'h1000_0000;
    localparam logic [31:0] START_W = 32'h0000_0001;
    localparam logic [31:0] DONE_W  = 32'h7fff_ffff;
    localparam logic [31:0] ABORT_W = 32'h0000_0000;

    localparam int K_RD   = 0;
    localparam int K_PH   = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;
    localparam int K_OVF  = 4;
    localparam int K_TOT  = 5;
    localparam int K_RDS  = 6;
    localparam int K_OVFS = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  rd_sel;

    logic [31:0] rd_data;
    logic [1:0]  phase;
    logic        busy, done;
    logic [3:0]  ovf;
    logic [3:0]  rd_data_s;
    logic [1:0]  phase_s;
    logic        busy_s, done_s;
    logic [3:0]  ovf_s;
`ifdef PHASE_TIMER_TOTAL_EN
    logic [31:0] total;
    logic [3:0]  total_s;
`endif

    phase_timer_ctrl #(
        .N_PHASES(4),
        .CNT_W   (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
`ifdef PHASE_TIMER_TOTAL_EN
        ,
        .total    (total)
`endif
    );

    // Narrow-counter instance sharing the same bus, used for saturation checks.
    phase_timer_ctrl #(
        .N_PHASES(4),
        .CNT_W   (4)
    ) dut_s (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data_s),
        .phase    (phase_s),
        .busy     (busy_s),
        .done     (done_s),
        .ovf      (ovf_s)
`ifdef PHASE_TIMER_TOTAL_EN
        ,
        .total    (total_s)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
        longint      due;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    longint      cyc = 0;
    int unsigned vals [4] = '{10, 25, 7, 100};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RD:   return rd_data;
            K_PH:   return 32'(phase);
            K_BUSY: return 32'(busy);
            K_DONE: return 32'(done);
            K_OVF:  return 32'(ovf);
`ifdef PHASE_TIMER_TOTAL_EN
            K_TOT:  return total;
`endif
            K_RDS:  return 32'(rd_data_s);
            K_OVFS: return 32'(ovf_s);
            default: return 32'hdead_beef;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (actual(e.kind) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                             e.name, actual(e.kind), e.val, cyc);
                end
            end
        end
    end

    task automatic chk(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        e.due  = cyc;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic v, input logic r);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = v;
        mem_ready = r;
        tick(1);
        mem_valid = 1'b0;
        mem_ready = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic marker(input logic [31:0] w);
        bus(MADDR, w, 4'hF, 1'b1, 1'b1);
    endtask

    // Places marker w exactly L clock edges after the previous marker edge.
    task automatic run_for(input int l, input logic [31:0] w);
        tick(l - 1);
        marker(w);
    endtask

    initial begin
        int unsigned prev;
        int unsigned sel;
        int          waitc;

        reset = 1'b1;
        mem_valid = 1'b0;
        mem_ready = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        rd_sel    = '0;
        tick(3);
        chk("rst_busy",  K_BUSY, 0);
        chk("rst_done",  K_DONE, 0);
        chk("rst_phase", K_PH,   0);
        chk("rst_ovf",   K_OVF,  0);
        chk("rst_rd",    K_RD,   0);
`ifdef PHASE_TIMER_TOTAL_EN
        chk("rst_total", K_TOT,  0);
`endif
        tick(1);
        reset = 1'b0;
        tick(2);

        // Basic four-phase run
        marker(START_W);
        chk("start_busy",  K_BUSY, 1);
        chk("start_phase", K_PH,   0);
        chk("start_done",  K_DONE, 0);
        run_for(10, DONE_W);
        chk("p0_closed_phase", K_PH, 1);
        run_for(25, DONE_W);
        run_for(7, DONE_W);
        chk("p2_closed_phase", K_PH,   3);
        chk("p2_closed_busy",  K_BUSY, 1);
        run_for(100, DONE_W);
        chk("run_done",  K_DONE, 1);
        chk("run_busy",  K_BUSY, 0);
        chk("run_phase", K_PH,   3);
        chk("run_ovf",   K_OVF,  0);
`ifdef PHASE_TIMER_TOTAL_EN
        chk("run_total", K_TOT, 142);
`endif

        // Readback sweep: old value until the next edge, then the selected count
        prev = vals[0];
        for (int i = 1; i <= 4; i++) begin
            sel = i % 4;
            rd_sel = 2'(sel);
            chk("rd_hold", K_RD, prev);
            tick(1);
            chk("rd_sweep", K_RD, vals[sel]);
            prev = vals[sel];
        end

        // Marker filtering: none of these may restart the finished run
        bus(MADDR,     START_W, 4'h3, 1'b1, 1'b1);
        bus(MADDR,     START_W, 4'h0, 1'b1, 1'b1);
        bus(MADDR + 4, START_W, 4'hF, 1'b1, 1'b1);
        bus(MADDR,     START_W, 4'hF, 1'b1, 1'b0);
        bus(MADDR,     START_W, 4'hF, 1'b0, 1'b1);
        tick(1);
        chk("filt_done",  K_DONE, 1);
        chk("filt_busy",  K_BUSY, 0);
        chk("filt_phase", K_PH,   3);
        chk("filt_rd0",   K_RD,   10);
        rd_sel = 2'd3;
        tick(1);
        chk("filt_rd3", K_RD, 100);

        // Abort retains counters and phase
        rd_sel = 2'd0;
        marker(START_W);
        chk("ab_start_busy", K_BUSY, 1);
        chk("ab_start_done", K_DONE, 0);
        run_for(5, DONE_W);
        run_for(8, ABORT_W);
        chk("ab_busy",  K_BUSY, 0);
        chk("ab_done",  K_DONE, 0);
        chk("ab_phase", K_PH,   1);
`ifdef PHASE_TIMER_TOTAL_EN
        chk("ab_total", K_TOT, 13);
`endif
        marker(DONE_W);
        chk("idle_done_ignored_busy",  K_BUSY, 0);
        chk("idle_done_ignored_phase", K_PH,   1);
        rd_sel = 2'd0;
        tick(1);
        chk("ab_cnt0", K_RD, 5);
        rd_sel = 2'd1;
        tick(1);
        chk("ab_cnt1", K_RD, 8);
        rd_sel = 2'd2;
        tick(1);
        chk("ab_cnt2_cleared", K_RD, 0);
        marker(START_W);
        chk("ab_restart_busy",  K_BUSY, 1);
        chk("ab_restart_phase", K_PH,   0);
        rd_sel = 2'd1;
        tick(1);
        chk("ab_restart_cnt1", K_RD, 0);

        // Saturation on the 4-bit instance (restart issued from RUN)
        rd_sel = 2'd0;
        marker(START_W);
        chk("sat_start_phase", K_PH,   0);
        chk("sat_start_ovfs",  K_OVFS, 0);
        run_for(20, DONE_W);
        chk("sat_phase", K_PH,   1);
        chk("sat_ovfs",  K_OVFS, 4'b0001);
        chk("sat_ovf",   K_OVF,  0);
        tick(1);
        chk("sat_rd_wide",   K_RD,  20);
        chk("sat_rd_narrow", K_RDS, 15);
        tick(5);
        chk("sat_ovfs_sticky", K_OVFS, 4'b0001);
        marker(START_W);
        chk("sat_ovfs_cleared", K_OVFS, 0);
        chk("sat_restart_phase", K_PH,  0);

        // Asynchronous reset between edges after 50 running cycles
        run_for(10, DONE_W);
        tick(40);
        chk("pre_rst_phase", K_PH,   1);
        chk("pre_rst_busy",  K_BUSY, 1);
        chk("pre_rst_rd",    K_RD,   10);
        chk("pre_rst_ovfs",  K_OVFS, 4'b0010);
        tick(1);
        #1;
        reset = 1'b1;
        chk("arst_busy",  K_BUSY, 0);
        chk("arst_done",  K_DONE, 0);
        chk("arst_phase", K_PH,   0);
        chk("arst_ovf",   K_OVF,  0);
        chk("arst_ovfs",  K_OVFS, 0);
        chk("arst_rd",    K_RD,   0);
        chk("arst_rds",   K_RDS,  0);
`ifdef PHASE_TIMER_TOTAL_EN
        chk("arst_total", K_TOT, 0);
`endif
        tick(2);
        reset = 1'b0;
        tick(2);
        marker(DONE_W);
        chk("post_rst_busy",  K_BUSY, 0);
        chk("post_rst_phase", K_PH,   0);

        waitc = 0;
        while (sb.size() > 0 && waitc < 100) begin
            tick(1);
            waitc++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
